// File: rtl/exp4_unidade_controle_if.sv
// Handshake bundle between the exp4 control unit and its datapath.
// The master side is the control unit: it reads datapath status and drives
// the control strobes. The slave side is the datapath (or a bench).
interface exp4_unidade_controle_if;
  logic       iniciar;
  logic       jogada_feita;
  logic       igual;
  logic       fimC;
  logic       timeout;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registrarR;
  logic       zera_timeout;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout_out;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, jogada_feita, igual, fimC, timeout,
    output zeraC, contaC, zeraR, registrarR, zera_timeout,
           pronto, acertou, errou, timeout_out, db_estado
  );

  modport slave (
    output iniciar, jogada_feita, igual, fimC, timeout,
    input  zeraC, contaC, zeraR, registrarR, zera_timeout,
           pronto, acertou, errou, timeout_out, db_estado
  );
endinterface

// File: rtl/exp4_unidade_controle.sv
// Moore control unit for the exp4 memory game. Waits for iniciar, then for each
// round waits for a play, registers it, compares it against the ROM word and
// either advances, wins, or ends with an error. A timeout while waiting for a
// play ends the game when TIMEOUT_EN is set. All outputs depend on state only.
module exp4_unidade_controle #(
  parameter bit TIMEOUT_EN = 1'b1
) (
  input logic                   clock,
  input logic                   reset,
  exp4_unidade_controle_if.master bus
);

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARACAO  = 4'b0001,
    ESPERA      = 4'b0010,
    REGISTRA    = 4'b0100,
    COMPARACAO  = 4'b0101,
    PROXIMO     = 4'b0110,
    FIM_ACERTO  = 4'b1010,
    FIM_ERRO    = 4'b1110,
    FIM_TIMEOUT = 4'b1101
  } estado_t;

  estado_t estado;
  estado_t proximo;

  // State register; reset takes effect immediately, independent of the clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo;
  end

  // Next-state decode; unused codes fall back to INICIAL on the next clock.
  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:     proximo = bus.iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:  proximo = ESPERA;
      ESPERA: begin
        // A play arriving together with the timeout still counts.
        if (bus.jogada_feita)                proximo = REGISTRA;
        else if (bus.timeout && TIMEOUT_EN)  proximo = FIM_TIMEOUT;
        else                                 proximo = ESPERA;
      end
      REGISTRA:    proximo = COMPARACAO;
      COMPARACAO: begin
        if (!bus.igual)     proximo = FIM_ERRO;
        else if (bus.fimC)  proximo = FIM_ACERTO;
        else                proximo = PROXIMO;
      end
      PROXIMO:     proximo = ESPERA;
      FIM_ACERTO:  proximo = bus.iniciar ? PREPARACAO : FIM_ACERTO;
      FIM_ERRO:    proximo = bus.iniciar ? PREPARACAO : FIM_ERRO;
      FIM_TIMEOUT: proximo = bus.iniciar ? PREPARACAO : FIM_TIMEOUT;
      default:     proximo = INICIAL;
    endcase
  end

  // Output decode from the current state only; illegal codes drive all zeros.
  always_comb begin
    bus.zeraC        = 1'b0;
    bus.contaC       = 1'b0;
    bus.zeraR        = 1'b0;
    bus.registrarR   = 1'b0;
    bus.zera_timeout = 1'b0;
    bus.pronto       = 1'b0;
    bus.acertou      = 1'b0;
    bus.errou        = 1'b0;
    bus.timeout_out  = 1'b0;
    case (estado)
      INICIAL: begin
        bus.zeraC = 1'b1;
        bus.zeraR = 1'b1;
      end
      PREPARACAO: begin
        bus.zeraC        = 1'b1;
        bus.zeraR        = 1'b1;
        bus.zera_timeout = 1'b1;
      end
      REGISTRA:  bus.registrarR = 1'b1;
      PROXIMO: begin
        // Restart the timeout window together with the address advance.
        bus.contaC       = 1'b1;
        bus.zera_timeout = 1'b1;
      end
      FIM_ACERTO: begin
        bus.pronto  = 1'b1;
        bus.acertou = 1'b1;
      end
      FIM_ERRO: begin
        bus.pronto = 1'b1;
        bus.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        bus.pronto      = 1'b1;
        bus.errou       = 1'b1;
        bus.timeout_out = 1'b1;
      end
      default: ;
    endcase
  end

  // Debug view of the state code for the 7-segment display.
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Bench for exp4_unidade_controle: a table of single-clock vectors followed by
// hand-written multi-cycle sequences (full win, error, async reset). A second
// instance with TIMEOUT_EN=0 receives the same inputs.
module tb_exp4_unidade_controle;

  // Output vector order: zeraC contaC zeraR registrarR zera_timeout pronto acertou errou timeout_out
  localparam logic [8:0] O_INI  = 9'b101000000;
  localparam logic [8:0] O_PREP = 9'b101010000;
  localparam logic [8:0] O_ESP  = 9'b000000000;
  localparam logic [8:0] O_REG  = 9'b000100000;
  localparam logic [8:0] O_COMP = 9'b000000000;
  localparam logic [8:0] O_PROX = 9'b010010000;
  localparam logic [8:0] O_ACE  = 9'b000001100;
  localparam logic [8:0] O_ERR  = 9'b000001010;
  localparam logic [8:0] O_TMO  = 9'b000001011;

  typedef struct {
    logic       ini, jog, igu, fim, tmo;
    logic [3:0] est;
    logic [8:0] outs;
    logic [3:0] est_b;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   checks    = 0;
  int   failures  = 0;
  int   conta_cnt = 0;
  vec_t vecs [17];

  always #5 clock = ~clock;

  exp4_unidade_controle_if a_if ();
  exp4_unidade_controle_if b_if ();

  assign b_if.iniciar      = a_if.iniciar;
  assign b_if.jogada_feita = a_if.jogada_feita;
  assign b_if.igual        = a_if.igual;
  assign b_if.fimC         = a_if.fimC;
  assign b_if.timeout      = a_if.timeout;

  exp4_unidade_controle #(.TIMEOUT_EN(1'b1)) dut_a (.clock(clock), .reset(reset), .bus(a_if));
  exp4_unidade_controle #(.TIMEOUT_EN(1'b0)) dut_b (.clock(clock), .reset(reset), .bus(b_if));

  function automatic logic [8:0] outs_a();
    return {a_if.zeraC, a_if.contaC, a_if.zeraR, a_if.registrarR, a_if.zera_timeout,
            a_if.pronto, a_if.acertou, a_if.errou, a_if.timeout_out};
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_in(input logic ini, input logic jog, input logic igu,
                        input logic fim, input logic tmo);
    a_if.iniciar      = ini;
    a_if.jogada_feita = jog;
    a_if.igual        = igu;
    a_if.fimC         = fim;
    a_if.timeout      = tmo;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (a_if.contaC) conta_cnt++;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic start_game();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    // ini jog igu fim tmo | estado  outputs  estado(TIMEOUT_EN=0)
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, O_INI,  4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, O_PREP, 4'b0001};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, O_ESP,  4'b0010};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, O_ESP,  4'b0010};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, O_REG,  4'b0100};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, O_COMP, 4'b0101};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, O_PROX, 4'b0110};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, O_ESP,  4'b0010};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, O_REG,  4'b0100};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, O_COMP, 4'b0101};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, O_ERR,  4'b1110};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, O_ERR,  4'b1110};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, O_PREP, 4'b0001};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, O_ESP,  4'b0010};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1101, O_TMO,  4'b0010};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1101, O_TMO,  4'b0010};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, O_PREP, 4'b0010};

    // Reset state
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("reset_estado", {5'b0, a_if.db_estado}, 9'd0);
    chk("reset_outs", outs_a(), O_INI);
    chk("reset_estado_b", {5'b0, b_if.db_estado}, 9'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single-clock vector table
    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].ini, vecs[i].jog, vecs[i].igu, vecs[i].fim, vecs[i].tmo);
      tick();
      chk($sformatf("vec%0d_estado", i), {5'b0, a_if.db_estado}, {5'b0, vecs[i].est});
      chk($sformatf("vec%0d_outs", i), outs_a(), vecs[i].outs);
      chk($sformatf("vec%0d_estado_b", i), {5'b0, b_if.db_estado}, {5'b0, vecs[i].est_b});
    end

    // Full win: 16 correct plays, fimC on the last one
    do_reset();
    start_game();
    conta_cnt = 0;
    for (int r = 0; r < 16; r++) begin
      set_in(1'b0, 1'b1, 1'b1, (r == 15), 1'b0);
      tick();
      set_in(1'b0, 1'b0, 1'b1, (r == 15), 1'b0);
      tick();
      tick();
      if (r < 15) begin
        tick();
        if (r == 0) chk("latencia_espera", {5'b0, a_if.db_estado}, 9'b000000010);
      end
    end
    chk("win_estado", {5'b0, a_if.db_estado}, 9'b000001010);
    chk("win_outs", outs_a(), O_ACE);
    chk("win_contaC", conta_cnt[8:0], 9'd15);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("win_hold", {5'b0, a_if.db_estado}, 9'b000001010);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("win_restart_outs", outs_a(), O_PREP);

    // Error on the third play, then async reset from FIM_ERRO
    do_reset();
    start_game();
    conta_cnt = 0;
    for (int r = 0; r < 3; r++) begin
      set_in(1'b0, 1'b1, (r < 2), 1'b0, 1'b0);
      tick();
      set_in(1'b0, 1'b0, (r < 2), 1'b0, 1'b0);
      tick();
      tick();
      if (r < 2) tick();
    end
    chk("err_estado", {5'b0, a_if.db_estado}, 9'b000001110);
    chk("err_outs", outs_a(), O_ERR);
    chk("err_contaC", conta_cnt[8:0], 9'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("err_async_reset_outs", outs_a(), O_INI);
    reset = 1'b0;

    // Async reset while in COMPARACAO
    do_reset();
    start_game();
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("comp_estado", {5'b0, a_if.db_estado}, 9'b000000101);
    #2;
    reset = 1'b1;
    #1;
    chk("comp_async_reset_estado", {5'b0, a_if.db_estado}, 9'd0);
    chk("comp_async_reset_outs", outs_a(), O_INI);
    reset = 1'b0;
    tick();
    chk("after_reset_idle", {5'b0, a_if.db_estado}, 9'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
